// File: rtl/data_mem_rv.sv
// data_mem_rv -- byte-addressable data memory with a valid/ready request
// channel and a valid/ready response channel.
//
// Accesses may be unaligned: byte lane i of a request targets byte address
// req_addr_i+i. An access that stays within one storage word completes in
// one cycle. An access that crosses into the next word takes two cycles,
// one per word. An access that touches a byte at or beyond SIZE_BYTES is
// rejected as a whole, and no byte is written.
//
// Ports
//   clk_i        clock, all state updates on rising edge
//   rst_ni       synchronous active-low reset (storage is not cleared)
//   req_valid_i  request present
//   req_ready_o  request accepted when high together with req_valid_i
//   req_write_i  1 = write, 0 = read
//   req_addr_i   byte address of lane 0
//   req_bsel_i   byte-lane enables
//   req_wdata_i  write data, lane i = bits 8i+7:8i
//   rsp_valid_o  response present
//   rsp_ready_i  response consumed when high together with rsp_valid_o
//   rsp_rdata_o  read data, lane-aligned like write data (0 for writes)
//   rsp_err_o    access error flag, valid with rsp_valid_o
module data_mem_rv #(
   parameter int unsigned ADDR_W     = 13,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned SIZE_BYTES = 8192
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_write_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [DATA_W/8-1:0] req_bsel_i,
   input  logic [DATA_W-1:0]   req_wdata_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [DATA_W-1:0]   rsp_rdata_o,
   output logic                rsp_err_o
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned WORDS = SIZE_BYTES / NB;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SECOND,
      RESP
   } state_t;

   state_t              state_q;

   logic [DATA_W-1:0]   mem [WORDS];

   // request latched at accept, used for the second word of a split access
   logic                write_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [NB-1:0]       bsel_q;
   logic [DATA_W-1:0]   wdata_q;

   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;

   // single word-access port shared by the accept cycle and SECOND
   logic                acc_second;
   logic [ADDR_W-1:0]   acc_addr;
   logic [NB-1:0]       acc_bsel;
   logic [DATA_W-1:0]   acc_wdata;
   logic [IDX_W-1:0]    acc_idx;
   logic [NB-1:0]       acc_be;
   logic [DATA_W-1:0]   acc_wbytes;
   logic [DATA_W-1:0]   acc_rdata;
   logic                req_err;
   logic                req_split;
   logic                accept;
   logic                mem_we;

   assign req_ready_o = (state_q == IDLE);
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

   assign accept = rst_ni && req_valid_i && (state_q == IDLE);
   assign mem_we = (accept && req_write_i && !req_err) ||
                   (rst_ni && (state_q == SECOND) && write_q);

   // Lane i lands at byte (off+i) of the first word, or byte (off+i-NB) of
   // the next word once it wraps past the word boundary. Each cycle serves
   // only the lanes belonging to the word currently being accessed, so the
   // write data and byte enables are rotated into word position and read
   // bytes are rotated back to lane position.
   always_comb begin
      int unsigned base;
      int unsigned off;
      int unsigned pos;
      acc_second = (state_q == SECOND);
      acc_addr   = acc_second ? addr_q  : req_addr_i;
      acc_bsel   = acc_second ? bsel_q  : req_bsel_i;
      acc_wdata  = acc_second ? wdata_q : req_wdata_i;
      base       = 32'(acc_addr) / NB;
      off        = 32'(acc_addr) % NB;
      acc_idx    = IDX_W'(base + (acc_second ? 32'd1 : 32'd0));
      acc_be     = '0;
      acc_wbytes = '0;
      acc_rdata  = '0;
      req_err    = 1'b0;
      req_split  = 1'b0;
      for (int unsigned i = 0; i < NB; i++) begin
         if (req_bsel_i[i] && (32'(req_addr_i) + i >= SIZE_BYTES)) begin
            req_err = 1'b1;
         end
         if (req_bsel_i[i] && ((32'(req_addr_i) % NB) + i >= NB)) begin
            req_split = 1'b1;
         end
         pos = off + i;
         if (acc_bsel[i] && ((pos >= NB) == acc_second)) begin
            if (pos >= NB) begin
               pos = pos - NB;
            end
            acc_be[pos]             = 1'b1;
            acc_wbytes[8*pos +: 8]  = acc_wdata[8*i +: 8];
            acc_rdata[8*i +: 8]     = mem[acc_idx][8*pos +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (acc_be[b]) begin
               mem[acc_idx][8*b +: 8] <= acc_wbytes[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  write_q <= req_write_i;
                  addr_q  <= req_addr_i;
                  bsel_q  <= req_bsel_i;
                  wdata_q <= req_wdata_i;
                  if (req_err) begin
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                     state_q <= RESP;
                  end else begin
                     err_q   <= 1'b0;
                     rdata_q <= req_write_i ? '0 : acc_rdata;
                     state_q <= req_split ? SECOND : RESP;
                  end
               end
            end
            SECOND: begin
               if (!write_q) begin
                  rdata_q <= rdata_q | acc_rdata;
               end
               state_q <= RESP;
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_rv.sv
module tb_data_mem_rv;

   localparam int unsigned AW = 13;
   localparam int unsigned DW = 32;
   localparam int unsigned NB = 4;
   localparam int unsigned SZ = 8192;

   logic          clk_i       = 1'b0;
   logic          rst_ni      = 1'b0;
   logic          req_valid_i = 1'b0;
   logic          req_write_i = 1'b0;
   logic [AW-1:0] req_addr_i  = '0;
   logic [NB-1:0] req_bsel_i  = '0;
   logic [DW-1:0] req_wdata_i = '0;
   logic          rsp_ready_i = 1'b0;
   logic          req_ready_o;
   logic          rsp_valid_o;
   logic [DW-1:0] rsp_rdata_o;
   logic          rsp_err_o;

   int total = 0;
   int bad   = 0;

   // reference byte image of the memory
   logic [7:0] ref_mem [SZ];

   always #5 clk_i = ~clk_i;

   data_mem_rv #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .SIZE_BYTES (SZ)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_write_i (req_write_i),
      .req_addr_i  (req_addr_i),
      .req_bsel_i  (req_bsel_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Byte-level behaviour: every selected byte address a+i must be inside the
   // memory, otherwise nothing happens; touching the next word costs a cycle.
   function automatic void model(input logic w, input logic [AW-1:0] a, input logic [NB-1:0] bs,
                                 input logic [DW-1:0] wd, output logic err, output int lat,
                                 output logic [DW-1:0] rd);
      int unsigned ba;
      err = 1'b0;
      lat = 1;
      rd  = '0;
      for (int unsigned i = 0; i < NB; i++)
         if (bs[i] && (int'(a) + i >= SZ)) err = 1'b1;
      if (!err) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (bs[i]) begin
               ba = int'(a) + i;
               if (ba / NB != int'(a) / NB) lat = 2;
               if (w) ref_mem[ba] = wd[8*i +: 8];
               else   rd[8*i +: 8] = ref_mem[ba];
            end
         end
      end
   endfunction

   // One full transaction with optional response backpressure; stray requests
   // are driven while busy and must be ignored.
   task automatic do_req(input string tag, input logic w, input logic [AW-1:0] a,
                         input logic [NB-1:0] bs, input logic [DW-1:0] wd, input int hold,
                         output logic [DW-1:0] rd_o);
      logic          e_err;
      int            e_lat;
      int            lat;
      logic [DW-1:0] e_rd;
      logic [DW-1:0] held;
      model(w, a, bs, wd, e_err, e_lat, e_rd);
      chk({tag, ".ready"}, 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_bsel_i = bs; req_wdata_i = wd;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0; req_write_i = 1'b1;
      req_addr_i  = AW'($urandom); req_bsel_i = NB'($urandom); req_wdata_i = $urandom;
      lat = 1;
      while (!rsp_valid_o && lat < 8) begin
         @(posedge clk_i); #1;
         lat++;
      end
      chk({tag, ".lat"}, 32'(lat), 32'(e_lat));
      chk({tag, ".err"}, 32'(rsp_err_o), 32'(e_err));
      chk({tag, ".rdata"}, rsp_rdata_o, e_rd);
      rd_o = rsp_rdata_o;
      held = rsp_rdata_o;
      for (int k = 0; k < hold; k++) begin
         req_valid_i = 1'b1;
         @(posedge clk_i); #1;
         chk({tag, ".hold_valid"}, 32'(rsp_valid_o), 32'd1);
         chk({tag, ".hold_rdata"}, rsp_rdata_o, held);
         chk({tag, ".hold_err"}, 32'(rsp_err_o), 32'(e_err));
         chk({tag, ".hold_ready"}, 32'(req_ready_o), 32'd0);
      end
      rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b0;
      chk({tag, ".done_valid"}, 32'(rsp_valid_o), 32'd0);
      chk({tag, ".done_ready"}, 32'(req_ready_o), 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] rd;
      logic [DW-1:0] wd;
      logic [AW-1:0] a;

      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst.ready", 32'(req_ready_o), 32'd1);
      chk("rst.valid", 32'(rsp_valid_o), 32'd0);
      chk("rst.err",   32'(rsp_err_o),   32'd0);
      chk("rst.rdata", rsp_rdata_o,      32'd0);
      rst_ni = 1'b1;

      for (int unsigned w = 0; w < SZ / NB; w++)
         do_req("init", 1'b1, AW'(w * NB), '1, $urandom, 0, rd);

      // aligned write then read back
      do_req("basic.wr", 1'b1, 13'h010, 4'b1111, 32'hA1B2C3D4, 0, rd);
      do_req("basic.rd", 1'b0, 13'h010, 4'b1111, 32'h0, 0, rd);
      chk("basic.val", rd, 32'hA1B2C3D4);

      // partial lanes over a known background
      do_req("part.bg",  1'b1, 13'h020, 4'b1111, 32'hFFFFFFFF, 0, rd);
      do_req("part.wr",  1'b1, 13'h020, 4'b0101, 32'h11223344, 0, rd);
      chk("part.wr_rdata", rd, 32'h0);
      do_req("part.rd",  1'b0, 13'h020, 4'b1111, 32'h0, 0, rd);
      chk("part.val", rd, 32'hFF22FF44);
      do_req("part.rd1", 1'b0, 13'h020, 4'b0010, 32'h0, 0, rd);
      chk("part.val1", rd, 32'h0000FF00);

      // word-crossing write
      do_req("split.z0", 1'b1, 13'h020, 4'b1111, 32'h0, 0, rd);
      do_req("split.z1", 1'b1, 13'h024, 4'b1111, 32'h0, 0, rd);
      do_req("split.wr", 1'b1, 13'h022, 4'b1111, 32'hDEADBEEF, 0, rd);
      do_req("split.r0", 1'b0, 13'h020, 4'b1111, 32'h0, 0, rd);
      chk("split.w0", rd, 32'hBEEF0000);
      do_req("split.r1", 1'b0, 13'h024, 4'b1111, 32'h0, 0, rd);
      chk("split.w1", rd, 32'h0000DEAD);
      do_req("split.rd", 1'b0, 13'h022, 4'b1111, 32'h0, 0, rd);
      chk("split.back", rd, 32'hDEADBEEF);

      // out-of-range access is rejected without writing anything
      do_req("err.pre", 1'b1, 13'h1FFC, 4'b1111, 32'h5A6B7C8D, 0, rd);
      do_req("err.wr",  1'b1, 13'h1FFE, 4'b1111, 32'h01020304, 0, rd);
      chk("err.rdata", rd, 32'h0);
      do_req("err.chk", 1'b0, 13'h1FFC, 4'b1111, 32'h0, 0, rd);
      chk("err.unchanged", rd, 32'h5A6B7C8D);
      do_req("err.ok",  1'b1, 13'h1FFE, 4'b0011, 32'h99887766, 0, rd);
      do_req("err.ok_rd", 1'b0, 13'h1FFC, 4'b1111, 32'h0, 0, rd);
      chk("err.ok_val", rd, 32'h77667C8D);
      do_req("bsel0", 1'b1, 13'h1FFF, 4'b0000, 32'hFFFFFFFF, 0, rd);

      // response backpressure
      do_req("bp.rd", 1'b0, 13'h010, 4'b1111, 32'h0, 5, rd);
      chk("bp.val", rd, 32'hA1B2C3D4);
      do_req("bp.split", 1'b0, 13'h023, 4'b1111, 32'h0, 5, rd);

      // reset while the second word of a split write is pending
      do_req("rs.z0", 1'b1, 13'h040, 4'b1111, 32'h0, 0, rd);
      do_req("rs.z1", 1'b1, 13'h044, 4'b1111, 32'h0, 0, rd);
      req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 13'h042;
      req_bsel_i = 4'b1111; req_wdata_i = 32'hCAFEF00D;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      chk("rs.second_valid", 32'(rsp_valid_o), 32'd0);
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      chk("rs.valid", 32'(rsp_valid_o), 32'd0);
      chk("rs.ready", 32'(req_ready_o), 32'd1);
      @(posedge clk_i); #1;
      chk("rs.valid_after", 32'(rsp_valid_o), 32'd0);
      ref_mem[13'h042] = 8'h0D;
      ref_mem[13'h043] = 8'hF0;
      do_req("rs.r0", 1'b0, 13'h040, 4'b1111, 32'h0, 0, rd);
      chk("rs.w0", rd, 32'hF00D0000);
      do_req("rs.r1", 1'b0, 13'h044, 4'b1111, 32'h0, 0, rd);
      chk("rs.w1", rd, 32'h00000000);

      // reset while a response is waiting
      req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 13'h010; req_bsel_i = 4'b1111;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      chk("rr.valid", 32'(rsp_valid_o), 32'd1);
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      chk("rr.dropped", 32'(rsp_valid_o), 32'd0);
      chk("rr.rdata", rsp_rdata_o, 32'h0);

      // randomized traffic, biased toward the top of memory
      for (int n = 0; n < 400; n++) begin
         a  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(SZ - 8, SZ - 1)) : AW'($urandom);
         wd = $urandom;
         do_req("rnd", 1'($urandom), a, NB'($urandom), wd, int'($urandom_range(0, 2)), rd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
